// File: rtl/diag_func_seq_pkg.sv
// Shared types and constants for the diagnostic function sequencer.
// Function codes use the console's octal notation.
package diag_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } diagSeqStateT;

  localparam logic [0:6] DIAG_FN_051 = 7'o051;
  localparam logic [0:6] DIAG_FN_052 = 7'o052;
  localparam logic [0:6] DIAG_FN_072 = 7'o072;
  localparam logic [0:6] DIAG_FN_073 = 7'o073;
  localparam logic [0:6] DIAG_FN_074 = 7'o074;
  localparam logic [0:6] DIAG_FN_075 = 7'o075;
  localparam logic [0:6] DIAG_FN_076 = 7'o076;

  // Bit positions of the decode outputs inside the packed decode vector.
  localparam int DEC_W   = 15;
  localparam int DEC_00X = 14;
  localparam int DEC_04X = 13;
  localparam int DEC_051 = 12;
  localparam int DEC_052 = 11;
  localparam int DEC_06X = 10;
  localparam int DEC_07X = 9;
  localparam int DEC_072 = 8;
  localparam int DEC_073 = 7;
  localparam int DEC_074 = 6;
  localparam int DEC_075 = 5;
  localparam int DEC_076 = 4;
  localparam int DEC_11X = 3;
  localparam int DEC_12X = 2;
  localparam int DEC_13X = 1;
  localparam int DEC_14X = 0;

  // Codes 0o100..0o177 are reads; bit 0 is the most significant bit.
  function automatic logic diagIsRead(input logic [0:6] code);
    return code[0];
  endfunction

endpackage

// File: rtl/diag_func_decode.sv
// Combinational function-code decode; all outputs forced low outside the envelope.
module diag_func_decode
  import diag_pkg::*;
(
  input  logic             en,
  input  logic [0:6]       code,
  output logic [DEC_W-1:0] dec
);

  logic [0:3] hi;
  assign hi = code[0:3];

  always_comb begin
    dec = '0;
    if (en) begin
      // Group decodes look only at the two high octal digits.
      dec[DEC_00X] = (hi == 4'd0);
      dec[DEC_04X] = (hi == 4'd4);
      dec[DEC_06X] = (hi == 4'd6);
      dec[DEC_07X] = (hi == 4'd7);
      dec[DEC_11X] = (hi == 4'd9);
      dec[DEC_12X] = (hi == 4'd10);
      dec[DEC_13X] = (hi == 4'd11);
      dec[DEC_14X] = (hi == 4'd12);
      dec[DEC_051] = (code == DIAG_FN_051);
      dec[DEC_052] = (code == DIAG_FN_052);
      dec[DEC_072] = (code == DIAG_FN_072);
      dec[DEC_073] = (code == DIAG_FN_073);
      dec[DEC_074] = (code == DIAG_FN_074);
      dec[DEC_075] = (code == DIAG_FN_075);
      dec[DEC_076] = (code == DIAG_FN_076);
    end
  end

endmodule

// File: rtl/diag_func_seq.sv
// Diagnostic function sequencer: latches one request, runs the setup/strobe/hold
// envelope toward the CTL diagnostic logic and returns EBUS data for reads.
module diag_func_seq
  import diag_pkg::*;
#(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        CROBAR,
  input  logic        req,
  input  logic [0:6]  reqFunc,
  input  logic [0:35] reqData,
  input  logic [0:35] ebusIn,
  output logic        ack,
  output logic        busy,
  output logic        done,
  output logic [0:35] rdData,
  output logic        rdValid,
  output logic [0:35] ebusOut,
  output logic        ebusDrive,
  output logic [0:6]  DIAG_DIAG,
  output logic        DIAG_STROBE,
  output logic        DIAG_READ,
  output logic        DIAG_CTL_FUNC_00x,
  output logic        DIAG_LD_FUNC_04x,
  output logic        diaFunc051,
  output logic        diaFunc052,
  output logic        DIAG_LOAD_FUNC_06x,
  output logic        DIAG_LOAD_FUNC_07x,
  output logic        DIAG_LOAD_FUNC_072,
  output logic        DIAG_LD_FUNC_073,
  output logic        DIAG_LD_FUNC_074,
  output logic        DIAG_SYNC_FUNC_075,
  output logic        DIAG_LD_FUNC_076,
  output logic        DIAG_READ_FUNC_11x,
  output logic        DIAG_READ_FUNC_12x,
  output logic        DIAG_READ_FUNC_13x,
  output logic        DIAG_READ_FUNC_14x
);

  localparam int MAX_SU  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_CYC = (MAX_SU > HOLD_CYC) ? MAX_SU : HOLD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  diagSeqStateT     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:6]       func_q, func_d;
  logic [0:35]      data_q, data_d;
  logic             accept, capture;

  logic             ack_q, ack_d, busy_q, busy_d, done_q, done_d;
  logic             rd_valid_q, rd_valid_d, strobe_q, strobe_d;
  logic             read_q, read_d, drive_q, drive_d;
  logic [0:35]      rd_data_q, rd_data_d, ebus_out_q, ebus_out_d;
  logic [0:6]       diag_q, diag_d;
  logic [DEC_W-1:0] dec_q, dec_d;
  logic             env_d, rd_d;

  always_ff @(posedge clk) begin
    if (CROBAR) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      func_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      func_q  <= func_d;
      data_q  <= data_d;
    end
  end

  // One down-counter is shared by all timed phases and reloaded on entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    func_d  = func_q;
    data_d  = data_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: if (req) begin
        accept  = 1'b1;
        state_d = ST_SETUP;
        cnt_d   = SETUP_LD;
        func_d  = reqFunc;
        data_d  = reqData;
      end
      ST_SETUP: if (cnt_q == '0) begin
        state_d = ST_STROBE;
        cnt_d   = STROBE_LD;
      end else cnt_d = cnt_q - CNT_W'(1);
      ST_STROBE: if (cnt_q == '0) begin
        state_d = ST_HOLD;
        cnt_d   = HOLD_LD;
      end else cnt_d = cnt_q - CNT_W'(1);
      ST_HOLD: if (cnt_q == '0) state_d = ST_DONE;
               else cnt_d = cnt_q - CNT_W'(1);
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  diag_func_decode u_decode (
    .en   (env_d),
    .code (func_d),
    .dec  (dec_d)
  );

  // Outputs are computed from the next state so they register in step with it.
  always_comb begin
    env_d      = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
    rd_d       = diagIsRead(func_d);
    capture    = (state_q == ST_STROBE) && (cnt_q == '0) && diagIsRead(func_q);
    ack_d      = accept;
    busy_d     = env_d;
    done_d     = (state_d == ST_DONE);
    rd_valid_d = done_d && rd_d;
    strobe_d   = (state_d == ST_STROBE);
    read_d     = env_d && rd_d;
    drive_d    = env_d && !rd_d;
    ebus_out_d = drive_d ? data_d : '0;
    diag_d     = env_d ? func_d : '0;
    rd_data_d  = capture ? ebusIn : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (CROBAR) begin
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      strobe_q   <= 1'b0;
      read_q     <= 1'b0;
      drive_q    <= 1'b0;
      rd_data_q  <= '0;
      ebus_out_q <= '0;
      diag_q     <= '0;
      dec_q      <= '0;
    end else begin
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      strobe_q   <= strobe_d;
      read_q     <= read_d;
      drive_q    <= drive_d;
      rd_data_q  <= rd_data_d;
      ebus_out_q <= ebus_out_d;
      diag_q     <= diag_d;
      dec_q      <= dec_d;
    end
  end

  assign ack                = ack_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign rdValid            = rd_valid_q;
  assign rdData             = rd_data_q;
  assign ebusOut            = ebus_out_q;
  assign ebusDrive          = drive_q;
  assign DIAG_DIAG          = diag_q;
  assign DIAG_STROBE        = strobe_q;
  assign DIAG_READ          = read_q;
  assign DIAG_CTL_FUNC_00x  = dec_q[DEC_00X];
  assign DIAG_LD_FUNC_04x   = dec_q[DEC_04X];
  assign diaFunc051         = dec_q[DEC_051];
  assign diaFunc052         = dec_q[DEC_052];
  assign DIAG_LOAD_FUNC_06x = dec_q[DEC_06X];
  assign DIAG_LOAD_FUNC_07x = dec_q[DEC_07X];
  assign DIAG_LOAD_FUNC_072 = dec_q[DEC_072];
  assign DIAG_LD_FUNC_073   = dec_q[DEC_073];
  assign DIAG_LD_FUNC_074   = dec_q[DEC_074];
  assign DIAG_SYNC_FUNC_075 = dec_q[DEC_075];
  assign DIAG_LD_FUNC_076   = dec_q[DEC_076];
  assign DIAG_READ_FUNC_11x = dec_q[DEC_11X];
  assign DIAG_READ_FUNC_12x = dec_q[DEC_12X];
  assign DIAG_READ_FUNC_13x = dec_q[DEC_13X];
  assign DIAG_READ_FUNC_14x = dec_q[DEC_14X];

endmodule

// File: doc/diag_func_seq.md
# diag_func_seq

Diagnostic function sequencer, directly upstream of the CTL board's diagnostic logic. It accepts one diagnostic function request at a time from the front-end console/DTE path: a 7-bit function code, 36-bit write data, and a valid/ack handshake. It then drives the CTL diagnostic function decodes, `DIAG_DIAG`, `DIAG_READ` and a timed `DIAG_STROBE` envelope. For read functions it captures EBUS data and returns it to the requester.

## Interface
Parameters:
- `SETUP_CYC`, default 2: cycles that decodes, `DIAG_DIAG` and write data are stable before the strobe; must be ≥1.
- `STROBE_CYC`, default 2: width of `DIAG_STROBE` in cycles; must be ≥1.
- `HOLD_CYC`, default 1: cycles that decodes and data are held after the strobe; must be ≥1.

Ports:
- `clk` in 1: system clock; the only clock.
- `CROBAR` in 1: reset, synchronous, active-high.
- `req` in 1: request valid; held until `ack`.
- `reqFunc` in [0:6]: diagnostic function code; 0o100–0o177 are reads.
- `reqData` in [0:35]: write data.
- `ebusIn` in [0:35]: EBUS data sampled for reads.
- `ack` out 1: one-cycle pulse, request accepted.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle pulse, sequence complete.
- `rdData` out [0:35]: captured read data.
- `rdValid` out 1: one-cycle pulse, `rdData` valid (reads only).
- `ebusOut` in-name out [0:35]: write data driven onto the EBUS.
- `ebusDrive` out 1: enable for `ebusOut`.
- `DIAG_DIAG` out [0:6]: latched function code.
- `DIAG_STROBE` out 1: function strobe.
- `DIAG_READ` out 1: read function active.
- Decode outputs, 1 bit each:
  - `DIAG_CTL_FUNC_00x`, `DIAG_LD_FUNC_04x`, `diaFunc051`, `diaFunc052`
  - `DIAG_LOAD_FUNC_06x`, `DIAG_LOAD_FUNC_07x`, `DIAG_LOAD_FUNC_072`
  - `DIAG_LD_FUNC_073`, `DIAG_LD_FUNC_074`, `DIAG_SYNC_FUNC_075`, `DIAG_LD_FUNC_076`
  - `DIAG_READ_FUNC_11x`, `DIAG_READ_FUNC_12x`, `DIAG_READ_FUNC_13x`, `DIAG_READ_FUNC_14x`

## Operation
- State machine: IDLE → SETUP → STROBE → HOLD → DONE → IDLE.
- Phase length is set by one shared down-counter, reloaded on each phase entry.
- **IDLE:** when `req`=1, latch `reqFunc` and `reqData`, then go to SETUP.
- **SETUP:** `ack`=1 in the first SETUP cycle only.
- **SETUP, STROBE, HOLD (the envelope):**
  - `busy`=1.
  - `DIAG_DIAG` = latched code.
  - Group decodes = 1 when the high digits of the code match (00x, 04x, 06x, 07x, 11x–14x).
  - Individual decodes = 1 on an exact code match (051, 052, 072–076). An exact match also asserts its group decode; e.g. 073 asserts both `DIAG_LOAD_FUNC_07x` and `DIAG_LD_FUNC_073`.
  - `DIAG_READ` = `DIAG_DIAG[0]`.
  - For writes, `ebusDrive`=1 and `ebusOut` = latched data. For reads, `ebusDrive`=0.
- **STROBE:** `DIAG_STROBE`=1. For reads, `rdData` ← `ebusIn` on the last STROBE cycle.
- **DONE:** one cycle with `done`=1 and `busy`=0. `rdValid`=1 for reads. All decodes and `DIAG_DIAG` are 0.
- Codes matching no decode still run the full sequence with all decodes 0.
- `req` while not in IDLE is ignored: no `ack`, no queuing.
- `req` in the DONE cycle is not accepted. It is accepted in the following IDLE cycle.

## Timing
- Reset values: every output is 0, including `rdData`; state is IDLE.
- Reset sampled in any state aborts the sequence. Outputs are 0 at the next edge, with no `done` and no `rdValid`.
- Latency, with `req` sampled at edge 0:
  - SETUP occupies cycles 1..SETUP_CYC.
  - STROBE occupies the next STROBE_CYC cycles.
  - HOLD occupies the next HOLD_CYC cycles.
  - `done` occurs in cycle SETUP_CYC+STROBE_CYC+HOLD_CYC+1; with defaults this is cycle 6.
- Minimum `req`-to-`req` acceptance spacing is SETUP+STROBE+HOLD+2 cycles (7 with defaults).
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `rdData` holds its value until the next read capture or reset.

## Structure
- Shared package `diag_pkg` holds:
  - the state enum `diagSeqStateT`;
  - octal function-code constants (e.g. `DIAG_FN_051`, `DIAG_FN_075`);
  - function `diagIsRead(code)`.
- Sub-module `diag_func_decode`: combinational map from a 7-bit code plus an envelope-active input to the 15 decode outputs. Its outputs are registered in the parent.
- Counter width is `$clog2(max(SETUP_CYC,STROBE_CYC,HOLD_CYC))+1`.

## Test plan
- **Write 042**, data 0o123456_701234, defaults:
  - `ack` in cycle 1.
  - `DIAG_LD_FUNC_04x` and `ebusDrive` high in cycles 1–5.
  - `DIAG_STROBE` high in cycles 3–4.
  - `done` in cycle 6; `rdValid` never asserts.
- **Read 124** with `ebusIn`=0o777000_000777 during STROBE:
  - `DIAG_READ` and `DIAG_READ_FUNC_12x` high in cycles 1–5.
  - `ebusDrive` stays 0.
  - `rdValid` in cycle 6 with `rdData`=0o777000_000777.
- **`req` held high continuously:**
  - Second `ack` arrives exactly 7 cycles after the first.
  - No `ack` occurs while `busy` is high.
- **Codes 051, 052, 072–076 in turn:** only the matching individual decode plus its group decode assert; all other decodes stay 0.
- **`CROBAR` asserted in the second STROBE cycle:**
  - All outputs 0 at the next edge; no `done` or `rdValid`.
  - The next `req` is accepted normally.
- **Parameters SETUP=1, STROBE=1, HOLD=1, code 0o177:**
  - `done` in cycle 4.
  - All decodes stay 0.
  - `DIAG_READ`=1 in cycles 1–3.
